// File: rtl/tdc_pulsegen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulsegen_pkg
// Description : Shared constants for the TDC test-pulse generator: CSR
//               register indices, CTRL/STATUS bit positions and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pulsegen_pkg;

    // Register indices, decoded from csr_a[2:0]
    localparam logic [2:0] c_reg_ctrl   = 3'd0;
    localparam logic [2:0] c_reg_period = 3'd1;
    localparam logic [2:0] c_reg_width  = 3'd2;
    localparam logic [2:0] c_reg_count  = 3'd3;
    localparam logic [2:0] c_reg_sent   = 3'd4;
    localparam logic [2:0] c_reg_status = 3'd5;

    // CTRL bit positions
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_stop  = 1;
    localparam int c_ctrl_cont  = 2;

    // STATUS bit positions
    localparam int c_status_done = 0;

    // Pulse FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tdc_pulsegen_core.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulsegen_core
// Description : Burst engine of the test-pulse generator. Snapshots the
//               clamped period/width/count at start, then walks HIGH/LOW
//               phases with a down-counter and counts completed pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pulsegen_core
    import tdc_pulsegen_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_cont,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic [CNT_WIDTH-1:0] i_width,
    input  logic [CNT_WIDTH-1:0] i_count,
    output logic                 o_pulse,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_sent
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_two = CNT_WIDTH'(2);

    state_t                 r_state_q, w_state_d;
    logic [CNT_WIDTH-1:0]   r_phase_q, w_phase_d;
    logic [CNT_WIDTH-1:0]   r_per_q,   w_per_d;
    logic [CNT_WIDTH-1:0]   r_wid_q,   w_wid_d;
    logic [CNT_WIDTH-1:0]   r_cnt_q,   w_cnt_d;
    logic                   r_cont_q,  w_cont_d;
    logic [CNT_WIDTH-1:0]   r_sent_q,  w_sent_d;
    logic                   r_pulse_q, w_pulse_d;
    logic                   w_done;

    logic [CNT_WIDTH-1:0]   w_period_clamp;
    logic [CNT_WIDTH-1:0]   w_period_m1;
    logic [CNT_WIDTH-1:0]   w_width_clamp;
    logic [CNT_WIDTH-1:0]   w_sent_inc;

    // A period below 2 cannot hold both a high and a low cycle, so the width
    // is forced into 1..P-1 to guarantee a real edge pair every period.
    assign w_period_clamp = (i_period < c_two) ? c_two : i_period;
    assign w_period_m1    = w_period_clamp - c_one;
    assign w_width_clamp  = (i_width == '0)         ? c_one       :
                            (i_width > w_period_m1) ? w_period_m1 : i_width;
    assign w_sent_inc     = r_sent_q + c_one;

    assign o_pulse = r_pulse_q;
    assign o_busy  = (r_state_q != ST_IDLE);
    assign o_done  = w_done;
    assign o_sent  = r_sent_q;

    // Next-state, phase counter and burst bookkeeping
    always_comb begin
        w_state_d = r_state_q;
        w_phase_d = r_phase_q;
        w_per_d   = r_per_q;
        w_wid_d   = r_wid_q;
        w_cnt_d   = r_cnt_q;
        w_cont_d  = r_cont_q;
        w_sent_d  = r_sent_q;
        w_done    = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_per_d  = w_period_clamp;
                    w_wid_d  = w_width_clamp;
                    w_cnt_d  = i_count;
                    w_cont_d = i_cont;
                    w_sent_d = '0;
                    // An empty one-shot burst completes immediately
                    if (!i_cont && (i_count == '0)) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_d = ST_HIGH;
                        w_phase_d = w_width_clamp;
                    end
                end
            end
            ST_HIGH: begin
                if (r_phase_q == c_one) begin
                    w_state_d = ST_LOW;
                    w_phase_d = r_per_q - r_wid_q;
                end else begin
                    w_phase_d = r_phase_q - c_one;
                end
            end
            ST_LOW: begin
                if (r_phase_q == c_one) begin
                    w_sent_d = w_sent_inc;
                    if (!r_cont_q && (w_sent_inc == r_cnt_q)) begin
                        w_state_d = ST_IDLE;
                        w_done    = 1'b1;
                    end else begin
                        w_state_d = ST_HIGH;
                        w_phase_d = r_wid_q;
                    end
                end else begin
                    w_phase_d = r_phase_q - c_one;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // STOP aborts from any state and never reports completion
        if (i_stop) begin
            w_state_d = ST_IDLE;
            w_done    = 1'b0;
        end

        w_pulse_d = (w_state_d == ST_HIGH);
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_phase_q <= '0;
            r_per_q   <= c_two;
            r_wid_q   <= c_one;
            r_cnt_q   <= c_one;
            r_cont_q  <= 1'b0;
            r_sent_q  <= '0;
            r_pulse_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_phase_q <= w_phase_d;
            r_per_q   <= w_per_d;
            r_wid_q   <= w_wid_d;
            r_cnt_q   <= w_cnt_d;
            r_cont_q  <= w_cont_d;
            r_sent_q  <= w_sent_d;
            r_pulse_q <= w_pulse_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdc_pulsegen.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulsegen
// Description : CSR-programmable TDC test-pulse generator. Holds the CSR
//               decode, configuration registers, registered readback and the
//               sticky DONE / one-cycle irq logic around the burst engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pulsegen
    import tdc_pulsegen_pkg::*;
#(
    parameter logic [3:0] CSR_ADDR  = 4'h2,
    parameter int         CNT_WIDTH = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic        pulse_o,
    output logic        busy_o
);

    logic                 w_bank_hit;
    logic [2:0]           w_idx;
    logic                 w_wr;
    logic                 w_wr_ctrl;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_cont_eff;
    logic                 w_start_acc;
    logic                 w_busy;
    logic                 w_core_done;
    logic [CNT_WIDTH-1:0] w_sent;
    logic [31:0]          w_rdata;
    logic                 w_unused_csr;

    logic [CNT_WIDTH-1:0] r_period_q, w_period_d;
    logic [CNT_WIDTH-1:0] r_width_q,  w_width_d;
    logic [CNT_WIDTH-1:0] r_count_q,  w_count_d;
    logic                 r_cont_q,   w_cont_d;
    logic                 r_done_q,   w_done_d;
    logic                 r_irq_q,    w_irq_d;
    logic [31:0]          r_csr_do_q, w_csr_do_d;

    assign w_bank_hit   = (csr_a[13:10] == CSR_ADDR);
    assign w_idx        = csr_a[2:0];
    assign w_wr         = csr_we && w_bank_hit;
    assign w_wr_ctrl    = w_wr && (w_idx == c_reg_ctrl);
    assign w_start      = w_wr_ctrl && csr_di[c_ctrl_start];
    assign w_stop       = w_wr_ctrl && csr_di[c_ctrl_stop];
    // A START write carrying CONT must launch a continuous burst directly
    assign w_cont_eff   = w_wr_ctrl ? csr_di[c_ctrl_cont] : r_cont_q;
    assign w_start_acc  = w_start && !w_stop && !w_busy;
    assign w_unused_csr = ^csr_a[9:3];

    assign csr_do  = r_csr_do_q;
    assign irq     = r_irq_q;
    assign busy_o  = w_busy;

    tdc_pulsegen_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .i_start  (w_start),
        .i_stop   (w_stop),
        .i_cont   (w_cont_eff),
        .i_period (r_period_q),
        .i_width  (r_width_q),
        .i_count  (r_count_q),
        .o_pulse  (pulse_o),
        .o_busy   (w_busy),
        .o_done   (w_core_done),
        .o_sent   (w_sent)
    );

    // Register writes, DONE set/clear priority and irq strobe
    always_comb begin
        w_period_d = r_period_q;
        w_width_d  = r_width_q;
        w_count_d  = r_count_q;
        w_cont_d   = r_cont_q;
        w_done_d   = r_done_q;
        w_irq_d    = w_core_done;

        if (w_wr) begin
            case (w_idx)
                c_reg_ctrl:   w_cont_d   = csr_di[c_ctrl_cont];
                c_reg_period: w_period_d = csr_di[CNT_WIDTH-1:0];
                c_reg_width:  w_width_d  = csr_di[CNT_WIDTH-1:0];
                c_reg_count:  w_count_d  = csr_di[CNT_WIDTH-1:0];
                c_reg_status: begin
                    if (csr_di[c_status_done]) begin
                        w_done_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (w_start_acc) begin
            w_done_d = 1'b0;
        end
        // Completion outranks a same-cycle W1C or start clear
        if (w_core_done) begin
            w_done_d = 1'b1;
        end
    end

    // Readback mux; zero whenever the bank does not match
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_reg_ctrl: begin
                w_rdata[c_ctrl_start] = w_busy;
                w_rdata[c_ctrl_cont]  = r_cont_q;
            end
            c_reg_period: w_rdata[CNT_WIDTH-1:0] = r_period_q;
            c_reg_width:  w_rdata[CNT_WIDTH-1:0] = r_width_q;
            c_reg_count:  w_rdata[CNT_WIDTH-1:0] = r_count_q;
            c_reg_sent:   w_rdata[CNT_WIDTH-1:0] = w_sent;
            c_reg_status: w_rdata[c_status_done] = r_done_q;
            default: ;
        endcase
        w_csr_do_d = w_bank_hit ? w_rdata : 32'd0;
    end

    // CSR registers, status and readback pipeline
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_period_q <= CNT_WIDTH'(2);
            r_width_q  <= CNT_WIDTH'(1);
            r_count_q  <= CNT_WIDTH'(1);
            r_cont_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_irq_q    <= 1'b0;
            r_csr_do_q <= 32'd0;
        end else begin
            r_period_q <= w_period_d;
            r_width_q  <= w_width_d;
            r_count_q  <= w_count_d;
            r_cont_q   <= w_cont_d;
            r_done_q   <= w_done_d;
            r_irq_q    <= w_irq_d;
            r_csr_do_q <= w_csr_do_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdc_pulsegen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_pulsegen
// Description : Scoreboard bench for tdc_pulsegen. Stimulus queues expected
//               per-cycle values and irq cycles; a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_pulsegen;

    localparam logic [3:0] c_bank  = 4'h2;
    localparam logic [3:0] c_other = 4'h3;
    localparam int c_sig_do    = 0;
    localparam int c_sig_pulse = 1;
    localparam int c_sig_busy  = 2;
    localparam int c_sig_irq   = 3;
    localparam int c_sig_edges = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [13:0] csr_a = 14'd0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = 32'd0;
    logic [31:0] csr_do;
    logic        irq;
    logic        pulse_o;
    logic        busy_o;

    exp_t exp_q[$];
    int   irq_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pulse_edges = 0;
    logic pulse_prev = 1'b0;
    int   edge_base = 0;
    logic end_req = 1'b0;
    int   n;

    tdc_pulsegen #(
        .CSR_ADDR  (4'h2),
        .CNT_WIDTH (32)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq),
        .pulse_o   (pulse_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Rising-edge counter for pulse_o
    always @(negedge clk) begin
        if (pulse_o && !pulse_prev) pulse_edges <= pulse_edges + 1;
        pulse_prev <= pulse_o;
    end

    // Monitor: compare every expectation due this cycle and every irq pulse
    always @(negedge clk) begin
        logic [31:0] act;
        int          e;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                case (exp_q[i].sig)
                    c_sig_do:    act = csr_do;
                    c_sig_pulse: act = {31'd0, pulse_o};
                    c_sig_busy:  act = {31'd0, busy_o};
                    c_sig_irq:   act = {31'd0, irq};
                    default:     act = 32'(pulse_edges - edge_base);
                endcase
                tests++;
                if (act !== exp_q[i].val) begin
                    fails++;
                    $display("FAIL %s @cycle %0d: actual 0x%08h, required 0x%08h",
                             exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (irq === 1'b1) begin
            tests++;
            if (irq_q.size() == 0) begin
                fails++;
                $display("FAIL irq_unexpected @cycle %0d: actual irq=1, required irq=0", cyc);
            end else begin
                e = irq_q.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL irq_timing: actual cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
        if (end_req) begin
            tests++;
            if (irq_q.size() != 0) begin
                fails++;
                $display("FAIL irq_missing: actual 0 pulses, required %0d more (next at cycle %0d)",
                         irq_q.size(), irq_q[0]);
            end
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL unchecked_expectations: actual %0d left, required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [31:0] v, input string nm);
        exp_t x;
        x.cyc  = c;
        x.sig  = s;
        x.val  = v;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic csr_wr(input logic [3:0] bank, input logic [2:0] idx, input logic [31:0] d);
        csr_a  = {bank, 7'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        tick(1);
        csr_we = 1'b0;
        csr_a  = 14'd0;
    endtask

    task automatic csr_rd(input logic [3:0] bank, input logic [2:0] idx,
                          input logic [31:0] v, input string nm);
        csr_a  = {bank, 7'd0, idx};
        csr_we = 1'b0;
        expect_at(cyc + 1, c_sig_do, v, nm);
        tick(1);
        csr_a  = 14'd0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    initial begin
        // Reset state
        tick(3);
        sys_rst_n = 1'b1;
        expect_at(cyc, c_sig_do,    0, "rst_csr_do");
        expect_at(cyc, c_sig_pulse, 0, "rst_pulse");
        expect_at(cyc, c_sig_busy,  0, "rst_busy");
        expect_at(cyc, c_sig_irq,   0, "rst_irq");
        tick(1);
        csr_rd(c_bank, 3'd0, 32'd0, "rst_ctrl");
        csr_rd(c_bank, 3'd1, 32'd2, "rst_period");
        csr_rd(c_bank, 3'd2, 32'd1, "rst_width");
        csr_rd(c_bank, 3'd3, 32'd1, "rst_count");
        csr_rd(c_bank, 3'd4, 32'd0, "rst_sent");
        csr_rd(c_bank, 3'd5, 32'd0, "rst_status");

        // One-shot: P=10, W=3, C=4, plus ignored START and WIDTH write mid-burst
        csr_wr(c_bank, 3'd1, 32'd10);
        csr_wr(c_bank, 3'd2, 32'd3);
        csr_wr(c_bank, 3'd3, 32'd4);
        n = cyc;
        for (int k = 1; k <= 45; k++) begin
            expect_at(n + k, c_sig_pulse, ((k <= 40) && (((k - 1) % 10) < 3)) ? 1 : 0, "oneshot_pulse");
            expect_at(n + k, c_sig_busy, (k <= 40) ? 1 : 0, "oneshot_busy");
        end
        irq_q.push_back(n + 41);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 15);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 20);
        csr_wr(c_bank, 3'd2, 32'd5);
        wait_until(n + 46);
        csr_rd(c_bank, 3'd4, 32'd4, "oneshot_sent");
        csr_rd(c_bank, 3'd5, 32'd1, "oneshot_done");
        csr_rd(c_bank, 3'd0, 32'd0, "oneshot_ctrl");
        csr_rd(c_bank, 3'd2, 32'd5, "midburst_width");

        // Clamping: P=1 -> 2, W=0 -> 1, C=2
        csr_wr(c_bank, 3'd1, 32'd1);
        csr_wr(c_bank, 3'd2, 32'd0);
        csr_wr(c_bank, 3'd3, 32'd2);
        csr_wr(c_bank, 3'd5, 32'd1);
        csr_rd(c_bank, 3'd5, 32'd0, "w1c_clear");
        n = cyc;
        for (int k = 1; k <= 6; k++) begin
            expect_at(n + k, c_sig_pulse, ((k <= 4) && (k % 2 == 1)) ? 1 : 0, "clamp_lo_pulse");
            expect_at(n + k, c_sig_busy, (k <= 4) ? 1 : 0, "clamp_lo_busy");
        end
        irq_q.push_back(n + 5);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 7);
        csr_rd(c_bank, 3'd4, 32'd2, "clamp_lo_sent");

        // Clamping: P=5, W=9 -> 4 high, 1 low
        csr_wr(c_bank, 3'd1, 32'd5);
        csr_wr(c_bank, 3'd2, 32'd9);
        csr_wr(c_bank, 3'd3, 32'd1);
        n = cyc;
        for (int k = 1; k <= 6; k++) begin
            expect_at(n + k, c_sig_pulse, (k <= 4) ? 1 : 0, "clamp_hi_pulse");
            expect_at(n + k, c_sig_busy, (k <= 5) ? 1 : 0, "clamp_hi_busy");
        end
        irq_q.push_back(n + 6);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 7);

        // COUNT=0: no pulse, done and irq at N+1
        csr_wr(c_bank, 3'd3, 32'd0);
        csr_wr(c_bank, 3'd5, 32'd1);
        n = cyc;
        for (int k = 1; k <= 3; k++) begin
            expect_at(n + k, c_sig_pulse, 0, "count0_pulse");
            expect_at(n + k, c_sig_busy, 0, "count0_busy");
        end
        irq_q.push_back(n + 1);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 3);
        csr_rd(c_bank, 3'd5, 32'd1, "count0_done");
        csr_rd(c_bank, 3'd4, 32'd0, "count0_sent");

        // DONE W1C in the same cycle DONE is set: set wins
        csr_wr(c_bank, 3'd5, 32'd1);
        csr_rd(c_bank, 3'd5, 32'd0, "w1c_clear2");
        csr_wr(c_bank, 3'd1, 32'd2);
        csr_wr(c_bank, 3'd2, 32'd1);
        csr_wr(c_bank, 3'd3, 32'd1);
        n = cyc;
        expect_at(n + 1, c_sig_pulse, 1, "w1c_race_pulse_hi");
        expect_at(n + 2, c_sig_pulse, 0, "w1c_race_pulse_lo");
        irq_q.push_back(n + 3);
        csr_wr(c_bank, 3'd0, 32'd1);
        wait_until(n + 2);
        csr_wr(c_bank, 3'd5, 32'd1);
        csr_rd(c_bank, 3'd5, 32'd1, "w1c_race_done");

        // START and STOP in one write: stays idle
        csr_wr(c_bank, 3'd5, 32'd1);
        csr_wr(c_bank, 3'd3, 32'd3);
        n = cyc;
        for (int k = 1; k <= 2; k++) begin
            expect_at(n + k, c_sig_pulse, 0, "startstop_pulse");
            expect_at(n + k, c_sig_busy, 0, "startstop_busy");
        end
        csr_wr(c_bank, 3'd0, 32'd3);
        wait_until(n + 3);
        csr_rd(c_bank, 3'd5, 32'd0, "startstop_done");

        // CSR bus: foreign bank, read-only and unused indices
        csr_rd(c_other, 3'd1, 32'd0, "other_bank_period");
        csr_rd(c_other, 3'd3, 32'd0, "other_bank_count");
        csr_wr(c_other, 3'd1, 32'd99);
        csr_rd(c_bank, 3'd1, 32'd2, "other_bank_write");
        csr_wr(c_bank, 3'd4, 32'h55);
        csr_rd(c_bank, 3'd4, 32'd1, "sent_readonly");
        csr_wr(c_bank, 3'd6, 32'hFFFF_FFFF);
        csr_wr(c_bank, 3'd7, 32'hFFFF_FFFF);
        csr_rd(c_bank, 3'd6, 32'd0, "idx6_zero");
        csr_rd(c_bank, 3'd7, 32'd0, "idx7_zero");
        csr_rd(c_bank, 3'd3, 32'd3, "count_after_idx67");

        // Continuous P=4, W=2, STOP 100 cycles after START
        csr_wr(c_bank, 3'd1, 32'd4);
        csr_wr(c_bank, 3'd2, 32'd2);
        csr_wr(c_bank, 3'd3, 32'd1);
        n = cyc;
        edge_base = pulse_edges;
        expect_at(n + 97,  c_sig_pulse, 1, "cont_last_hi");
        expect_at(n + 99,  c_sig_pulse, 0, "cont_last_lo");
        expect_at(n + 101, c_sig_pulse, 0, "cont_stop_pulse");
        expect_at(n + 101, c_sig_busy,  0, "cont_stop_busy");
        expect_at(n + 102, c_sig_pulse, 0, "cont_stop_pulse2");
        expect_at(n + 103, c_sig_edges, 25, "cont_pulse_count");
        csr_wr(c_bank, 3'd0, 32'd5);
        wait_until(n + 50);
        csr_rd(c_bank, 3'd0, 32'd5, "cont_ctrl_busy");
        wait_until(n + 100);
        csr_wr(c_bank, 3'd0, 32'd6);
        wait_until(n + 104);
        csr_rd(c_bank, 3'd5, 32'd0, "cont_no_done");
        csr_rd(c_bank, 3'd0, 32'd4, "cont_ctrl_idle");

        // Reset for one cycle during HIGH
        csr_wr(c_bank, 3'd1, 32'd10);
        csr_wr(c_bank, 3'd2, 32'd5);
        csr_wr(c_bank, 3'd3, 32'd3);
        n = cyc;
        expect_at(n + 1, c_sig_pulse, 1, "prerst_pulse");
        expect_at(n + 2, c_sig_busy,  1, "prerst_busy");
        expect_at(n + 3, c_sig_pulse, 0, "midrst_pulse");
        expect_at(n + 3, c_sig_busy,  0, "midrst_busy");
        expect_at(n + 3, c_sig_do,    0, "midrst_csr_do");
        expect_at(n + 3, c_sig_irq,   0, "midrst_irq");
        csr_wr(c_bank, 3'd0, 32'd5);
        wait_until(n + 2);
        sys_rst_n = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        csr_rd(c_bank, 3'd1, 32'd2, "midrst_period");
        csr_rd(c_bank, 3'd2, 32'd1, "midrst_width");
        csr_rd(c_bank, 3'd3, 32'd1, "midrst_count");
        csr_rd(c_bank, 3'd0, 32'd0, "midrst_ctrl");
        csr_rd(c_bank, 3'd4, 32'd0, "midrst_sent");
        csr_rd(c_bank, 3'd5, 32'd0, "midrst_status");

        tick(3);
        end_req = 1'b1;
        tick(5);
    end

endmodule
`default_nettype wire
